mdu_sequencer: RTL

Multi-cycle multiply/accumulate sequencer for the pipelined MIPS core. It owns the HI/LO register pair and executes MULTU and MADDU with one shift-add step per cycle. While it is busy, it stalls the pipeline front-end against any instruction that needs the unit or HI/LO. It sits beside the EX stage and is launched by the decode/EX control path when the decoded opcode/funct selects MULTU or MADDU (opcode 28).

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mdu_shift_add_step.sv | 23 ++
 rtl/mdu_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core.
//   mdu_state_t : state encoding of the multiply/accumulate sequencer.
//   Opcode and funct constants used by the decode/EX control path to select
//   MULTU / MADDU / MFHI / MFLO.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } mdu_state_t;

    // Opcodes
    localparam logic [5:0] R_FORMAT = 6'd0;
    localparam logic [5:0] J        = 6'd2;
    localparam logic [5:0] BEQ      = 6'd4;
    localparam logic [5:0] ADDIU    = 6'd9;
    localparam logic [5:0] MADDU    = 6'd28;
    localparam logic [5:0] LW       = 6'd35;
    localparam logic [5:0] SW       = 6'd43;

    // R-format funct codes
    localparam logic [5:0] MULTU    = 6'h19;
    localparam logic [5:0] MFHI     = 6'h10;
    localparam logic [5:0] MFLO     = 6'h12;

endpackage

// File: rtl/mdu_shift_add_step.sv
// One shift-add multiplication step, purely combinational.
//   prod_i       : running 2*WIDTH-bit partial product
//   mcand_i      : multiplicand
//   mplier_lsb_i : current multiplier bit
//   prod_o       : partial product after conditional add and right shift
module mdu_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic               mplier_lsb_i,
    output logic [2*WIDTH-1:0] prod_o
);

    // The add is one bit wider so its carry becomes the new top bit after
    // the shift instead of being lost.
    logic [WIDTH:0] sum;

    assign sum    = {1'b0, prod_i[2*WIDTH-1:WIDTH]}
                  + (mplier_lsb_i ? {1'b0, mcand_i} : '0);
    assign prod_o = (2*WIDTH)'({sum, prod_i[WIDTH-1:0]} >> 1);

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULTU / MADDU sequencer owning the HI/LO register pair.
//   clk, rst    : clock and synchronous active-high reset
//   Start       : one-cycle launch request, samples Accumulate/SrcA/SrcB
//   Accumulate  : 1 = MADDU ({HI,LO} += product), 0 = MULTU
//   SrcA, SrcB  : multiplicand / multiplier
//   HiLoRead    : ID stage holds MFHI/MFLO
//   Abort       : flush of the owning instruction
//   Busy        : operation in progress (RUN or WRITE)
//   Stall       : freeze PC/IF/ID while busy against Start or HiLoRead
//   Done        : one-cycle pulse in the cycle HI/LO are written
//   HiOut/LoOut : HI and LO registers
module mdu_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Accumulate,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiLoRead,
    input  logic             Abort,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mdu_state_t         state_q,  state_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               acc_q,    acc_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [CW-1:0]      count_q,  count_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic [2*WIDTH-1:0] prod_step;

    mdu_shift_add_step #(.WIDTH(WIDTH)) u_step (
        .prod_i       (prod_q),
        .mcand_i      (mcand_q),
        .mplier_lsb_i (mplier_q[0]),
        .prod_o       (prod_step)
    );

    assign Busy  = (state_q != IDLE);
    assign Stall = Busy & (Start | HiLoRead);
    assign HiOut = hi_q;
    assign LoOut = lo_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // can leave one unassigned and infer a latch.
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        Done     = 1'b0;

        case (state_q)
            IDLE: begin
                // Abort outranks a same-cycle Start: nothing launches.
                if (Start && !Abort) begin
                    mcand_d  = SrcA;
                    mplier_d = SrcB;
                    acc_d    = Accumulate;
                    prod_d   = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (Abort) begin
                    state_d = IDLE;
                end else begin
                    prod_d   = prod_step;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST_STEP) state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                // An abort landing on the write cycle cancels the commit.
                if (!Abort) begin
                    {hi_d, lo_d} = acc_q ? ({hi_q, lo_q} + prod_q) : prod_q;
                    Done         = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of the others.
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= 1'b0;
            prod_q   <= '0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
